// File: rtl/motion_tracker_pkg.sv
// motion_tracker_pkg: widths, FSM state types and record structs for motion_centroid_tracker
package motion_tracker_pkg;
  localparam int INPUT_W = 10;
  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int CNT_W = X_W + Y_W;
  localparam int SX_W = X_W + CNT_W;
  localparam int SY_W = Y_W + CNT_W;
  localparam int MIN_CNT = 16;
  localparam int DIV_SW = $clog2(SX_W + 1);
  typedef enum logic {A_IDLE, A_ACCUM} acc_state_e;
  typedef enum logic [1:0] {R_IDLE, R_DIVX, R_DIVY, R_HOLD} res_state_e;
  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [X_W-1:0] x_min;
    logic [X_W-1:0] x_max;
    logic [Y_W-1:0] y_min;
    logic [Y_W-1:0] y_max;
  } stats_t;
  typedef struct packed {
    logic found;
    logic [CNT_W-1:0] count;
    logic [X_W-1:0] x_min;
    logic [X_W-1:0] x_max;
    logic [Y_W-1:0] y_min;
    logic [Y_W-1:0] y_max;
    logic [X_W-1:0] cx;
    logic [Y_W-1:0] cy;
  } result_t;
  localparam stats_t STATS_INIT = '{count: '0, x_min: {X_W{1'b1}}, x_max: '0, y_min: {Y_W{1'b1}}, y_max: '0};
endpackage

// File: rtl/serial_divider.sv
// serial_divider: restoring divider, one quotient bit per cycle; divide-by-zero yields 0
module serial_divider #(
  parameter int NW = 29,
  parameter int DW = 19,
  parameter int SW = $clog2(NW + 1)
) (
  input  logic          clk,
  input  logic          aresetn,
  input  logic          start,
  input  logic [SW-1:0] steps,
  input  logic [NW-1:0] num,
  input  logic [DW-1:0] den,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] quotient
);
  logic          busy_q, busy_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rem_q, rem_d, den_q, den_d;
  logic [NW-1:0] quo_q, quo_d, quo_n;
  logic [DW:0]   rem_sh;
  logic          ge;
  // One restoring step per busy cycle; done flags the final step, whose quotient is presented combinationally
  always_comb begin
    rem_sh = {rem_q, quo_q[NW-1]};
    ge = rem_sh >= {1'b0, den_q};
    quo_n = {quo_q[NW-2:0], ge};
    done = busy_q && cnt_q == SW'(1);
    busy_d = start | (busy_q & ~done);
    cnt_d = start ? steps : busy_q ? cnt_q - SW'(1) : cnt_q;
    rem_d = start ? '0 : busy_q ? (ge ? rem_sh[DW-1:0] - den_q : rem_sh[DW-1:0]) : rem_q;
    quo_d = start ? num : busy_q ? quo_n : quo_q;
    den_d = start ? den : den_q;
  end
  // Divider state registers
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      busy_q <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      den_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      den_q <= den_d;
    end
  end
  assign busy = busy_q;
  assign quotient = den_q == '0 ? '0 : quo_n;
endmodule

// File: rtl/motion_centroid_tracker.sv
// motion_centroid_tracker: per-frame motion count, bounding box and centroid; MOTION_CENTROID_ROUND_EN selects round-half-up centroid
import motion_tracker_pkg::*;
module motion_centroid_tracker #(
  parameter int INPUT_WIDTH = INPUT_W,
  parameter int X_WIDTH = X_W,
  parameter int Y_WIDTH = Y_W,
  parameter int CNT_WIDTH = CNT_W,
  parameter int MIN_COUNT = MIN_CNT
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic                   in_eol,
  input  logic                   in_eof,
  input  logic [INPUT_WIDTH-1:0] in_pixel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   found,
  output logic [CNT_WIDTH-1:0]   count,
  output logic [X_WIDTH-1:0]     x_min,
  output logic [X_WIDTH-1:0]     x_max,
  output logic [Y_WIDTH-1:0]     y_min,
  output logic [Y_WIDTH-1:0]     y_max,
  output logic [X_WIDTH-1:0]     cx,
  output logic [Y_WIDTH-1:0]     cy,
  output logic                   overrun
);
  acc_state_e a_q, a_d;
  res_state_e r_q, r_d;
  logic [X_W-1:0] x_q, x_d, px, cx_q, cx_d;
  logic [Y_W-1:0] y_q, y_d, py;
  stats_t acc_q, acc_d, ab, snap_q, snap_d;
  logic [SX_W-1:0] sx_q, sx_d, sxb, rnd_x;
  logic [SY_W-1:0] sy_q, sy_d, syb, snap_sy_q, snap_sy_d, rnd_y;
  result_t res_q, res_d;
  logic eof_q, eof_d, valid_q, valid_d, ovr_q, ovr_d;
  logic take, fg, clr, accept, start_y, publish, zero_cnt;
  logic div_start, div_busy, div_done;
  logic [DIV_SW-1:0] div_steps;
  logic [SX_W-1:0] div_num, div_quo;
  logic [CNT_W-1:0] div_den;
  logic unused_bits;
`ifdef MOTION_CENTROID_ROUND_EN
  assign rnd_x = SX_W'(acc_q.count >> 1);
  assign rnd_y = SY_W'(snap_q.count >> 1);
`else
  assign rnd_x = '0;
  assign rnd_y = '0;
`endif
  // Raster coordinates of the current pixel and accumulation of foreground statistics
  always_comb begin
    px = in_sof ? '0 : x_q;
    py = in_sof ? '0 : y_q;
    x_d = !in_valid ? x_q : in_eol ? '0 : px + X_W'(~&px);
    y_d = !in_valid ? y_q : py + Y_W'(in_eol & ~&py);
    fg = in_pixel[INPUT_WIDTH-1];
    take = in_valid & (in_sof | a_q == A_ACCUM);
    clr = (in_valid & in_sof) | eof_q;
    ab = clr ? STATS_INIT : acc_q;
    sxb = clr ? '0 : sx_q;
    syb = clr ? '0 : sy_q;
    acc_d = ab;
    sx_d = sxb;
    sy_d = syb;
    if (take & fg) begin
      acc_d.count = ab.count + CNT_W'(1);
      acc_d.x_min = px < ab.x_min ? px : ab.x_min;
      acc_d.x_max = px > ab.x_max ? px : ab.x_max;
      acc_d.y_min = py < ab.y_min ? py : ab.y_min;
      acc_d.y_max = py > ab.y_max ? py : ab.y_max;
      sx_d = sxb + SX_W'(px);
      sy_d = syb + SY_W'(py);
    end
    eof_d = take & in_eof;
    a_d = eof_d ? A_IDLE : (in_valid & in_sof) ? A_ACCUM : a_q;
  end
  // Snapshot, X-then-Y centroid division and the held result record
  always_comb begin
    accept = eof_q & (r_q == R_IDLE | r_q == R_HOLD);
    start_y = r_q == R_DIVY & ~div_busy;
    div_start = accept | start_y;
    div_steps = start_y ? DIV_SW'(SY_W) : DIV_SW'(SX_W);
    div_num = start_y ? {snap_sy_q + rnd_y, 1'b0} : sx_q + rnd_x;
    div_den = start_y ? snap_q.count : acc_q.count;
    snap_d = accept ? acc_q : snap_q;
    snap_sy_d = accept ? sy_q : snap_sy_q;
    cx_d = (r_q == R_DIVX & div_done) ? div_quo[X_W-1:0] : cx_q;
    publish = r_q == R_DIVY & div_done;
    zero_cnt = snap_q.count == '0;
    res_d = !publish ? res_q : result_t'{
      found: snap_q.count >= CNT_W'(MIN_COUNT),
      count: snap_q.count,
      x_min: zero_cnt ? '0 : snap_q.x_min,
      x_max: zero_cnt ? '0 : snap_q.x_max,
      y_min: zero_cnt ? '0 : snap_q.y_min,
      y_max: zero_cnt ? '0 : snap_q.y_max,
      cx: cx_q,
      cy: div_quo[Y_W-1:0]};
    valid_d = publish | (valid_q & ~out_ready);
    ovr_d = ovr_q | (eof_q & ~accept) | (eof_q & r_q == R_HOLD & ~out_ready);
    r_d = accept ? R_DIVX :
          (r_q == R_DIVX & div_done) ? R_DIVY :
          publish ? R_HOLD :
          (r_q == R_HOLD & valid_q & out_ready) ? R_IDLE : r_q;
  end
  // State and datapath registers
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      a_q <= A_IDLE;
      r_q <= R_IDLE;
      x_q <= '0;
      y_q <= '0;
      acc_q <= STATS_INIT;
      sx_q <= '0;
      sy_q <= '0;
      snap_q <= '0;
      snap_sy_q <= '0;
      cx_q <= '0;
      res_q <= '0;
      eof_q <= 1'b0;
      valid_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      a_q <= a_d;
      r_q <= r_d;
      x_q <= x_d;
      y_q <= y_d;
      acc_q <= acc_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
      snap_q <= snap_d;
      snap_sy_q <= snap_sy_d;
      cx_q <= cx_d;
      res_q <= res_d;
      eof_q <= eof_d;
      valid_q <= valid_d;
      ovr_q <= ovr_d;
    end
  end
  serial_divider #(.NW(SX_W), .DW(CNT_W), .SW(DIV_SW)) u_div (
    .clk(clk), .aresetn(aresetn), .start(div_start), .steps(div_steps), .num(div_num),
    .den(div_den), .busy(div_busy), .done(div_done), .quotient(div_quo)
  );
  assign unused_bits = ^{in_pixel[INPUT_WIDTH-2:0], div_quo[SX_W-1:X_W]};
  assign out_valid = valid_q;
  assign found = res_q.found;
  assign count = res_q.count;
  assign x_min = res_q.x_min;
  assign x_max = res_q.x_max;
  assign y_min = res_q.y_min;
  assign y_max = res_q.y_max;
  assign cx = res_q.cx;
  assign cy = res_q.cy;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_motion_centroid_tracker.sv
// tb_motion_centroid_tracker: scoreboard bench for motion_centroid_tracker
module tb_motion_centroid_tracker;
`ifdef MOTION_CENTROID_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  localparam int RW = 1 + 19 + 10 + 10 + 9 + 9 + 10 + 9;
  typedef struct {
    int count, x_min, x_max, y_min, y_max, cx, cy, eof_cyc;
    bit found;
  } exp_t;
  logic clk = 0, aresetn = 0;
  logic in_valid = 0, in_sof = 0, in_eol = 0, in_eof = 0, out_ready = 0;
  logic [9:0] in_pixel = '0;
  logic out_valid, found, overrun;
  logic [18:0] count;
  logic [9:0] x_min, x_max, cx;
  logic [8:0] y_min, y_max, cy;
  int cyc = 0, checks = 0, passes = 0;
  exp_t q[$];
  motion_centroid_tracker dut (
    .clk(clk), .aresetn(aresetn), .in_valid(in_valid), .in_sof(in_sof), .in_eol(in_eol),
    .in_eof(in_eof), .in_pixel(in_pixel), .out_valid(out_valid), .out_ready(out_ready),
    .found(found), .count(count), .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .cx(cx), .cy(cy), .overrun(overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [RW-1:0] act_vec();
    return {found, count, x_min, x_max, y_min, y_max, cx, cy};
  endfunction
  function automatic logic [RW-1:0] exp_vec(input exp_t e);
    return {e.found, 19'(e.count), 10'(e.x_min), 10'(e.x_max), 9'(e.y_min), 9'(e.y_max), 10'(e.cx), 9'(e.cy)};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    aresetn = 0;
    tick();
    tick();
    aresetn = 1;
    tick();
  endtask
  // drives a w x h frame with a foreground rectangle; stop >= 0 aborts after that many pixels
  task automatic drive_frame(input int w, h, x0, x1, y0, y1, gap, stop);
    exp_t e;
    int n = 0;
    bit f;
    e = '{count: 0, x_min: 1 << 30, x_max: 0, y_min: 1 << 30, y_max: 0, cx: 0, cy: 0, eof_cyc: 0, found: 0};
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (stop >= 0 && n == stop) begin
          in_valid = 0;
          return;
        end
        while (gap > 0 && $urandom_range(99) < gap) begin
          in_valid = 0;
          tick();
        end
        f = x >= x0 && x <= x1 && y >= y0 && y <= y1;
        in_valid = 1;
        in_sof = x == 0 && y == 0;
        in_eol = x == w - 1;
        in_eof = x == w - 1 && y == h - 1;
        in_pixel = {f, 9'($urandom_range(511))};
        tick();
        n++;
        if (f) begin
          e.count++;
          e.cx += x;
          e.cy += y;
          if (x < e.x_min) e.x_min = x;
          if (x > e.x_max) e.x_max = x;
          if (y < e.y_min) e.y_min = y;
          if (y > e.y_max) e.y_max = y;
        end
      end
    end
    in_valid = 0;
    in_sof = 0;
    in_eol = 0;
    in_eof = 0;
    if (e.count == 0) begin
      e.x_min = 0;
      e.y_min = 0;
    end else begin
      e.cx = (e.cx + (RND ? e.count / 2 : 0)) / e.count;
      e.cy = (e.cy + (RND ? e.count / 2 : 0)) / e.count;
    end
    e.found = e.count >= 16;
    e.eof_cyc = cyc;
    q.push_back(e);
  endtask
  task automatic wait_valid(input int eof_c, output int lat);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      if (out_valid) begin
        lat = cyc - eof_c;
        break;
      end
      tick();
    end
  endtask
  task automatic accept();
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask
  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({out_valid, overrun} !== 2'b00) $display("FAIL reset_flags: got valid/overrun %b, want 00", {out_valid, overrun});
    else passes++;
    checks++;
    if (act_vec() !== '0) $display("FAIL reset_rec: got %h, want 0", act_vec());
    else passes++;
    aresetn = 1;
    tick();
  endtask
  task automatic test_single();
    exp_t e;
    int lat;
    drive_frame(8, 4, 5, 5, 3, 3, 0, -1);
    e = q.pop_front();
    wait_valid(e.eof_cyc, lat);
    checks++;
    if (lat !== 59) $display("FAIL single_latency: got %0d, want 59", lat);
    else passes++;
    checks++;
    if (act_vec() !== exp_vec(e)) $display("FAIL single_rec: got %h, want %h", act_vec(), exp_vec(e));
    else passes++;
    accept();
    checks++;
    if (out_valid !== 1'b0) $display("FAIL single_ack: got out_valid %b, want 0", out_valid);
    else passes++;
  endtask
  task automatic test_block();
    exp_t e;
    int lat;
    drive_frame(64, 32, 10, 13, 20, 23, 0, -1);
    e = q.pop_front();
    wait_valid(e.eof_cyc, lat);
    checks++;
    if (lat !== 59) $display("FAIL block_latency: got %0d, want 59", lat);
    else passes++;
    checks++;
    if (act_vec() !== exp_vec(e)) $display("FAIL block_rec: got %h, want %h", act_vec(), exp_vec(e));
    else passes++;
    checks++;
    if ({cx, cy} !== (RND ? {10'd12, 9'd22} : {10'd11, 9'd21})) $display("FAIL block_centroid: got %0d,%0d, want %0d,%0d", cx, cy, RND ? 12 : 11, RND ? 22 : 21);
    else passes++;
    accept();
  endtask
  task automatic test_empty();
    exp_t e;
    int lat;
    drive_frame(16, 4, 1, 0, 1, 0, 0, -1);
    e = q.pop_front();
    wait_valid(e.eof_cyc, lat);
    checks++;
    if (lat !== 59) $display("FAIL empty_latency: got %0d, want 59", lat);
    else passes++;
    checks++;
    if (act_vec() !== exp_vec(e)) $display("FAIL empty_rec: got %h, want %h", act_vec(), exp_vec(e));
    else passes++;
    accept();
  endtask
  task automatic test_gaps();
    exp_t e;
    int lat;
    drive_frame(64, 32, 10, 13, 20, 23, 30, -1);
    e = q.pop_front();
    wait_valid(e.eof_cyc, lat);
    checks++;
    if (act_vec() !== exp_vec(e)) $display("FAIL gaps_rec: got %h, want %h", act_vec(), exp_vec(e));
    else passes++;
    accept();
  endtask
  task automatic test_hold_overrun();
    exp_t e;
    int lat;
    drive_frame(64, 32, 10, 13, 20, 23, 0, -1);
    wait_valid(q[0].eof_cyc, lat);
    drive_frame(64, 32, 30, 34, 5, 8, 0, -1);
    void'(q.pop_front());
    e = q.pop_front();
    for (int i = 0; i < 70; i++) tick();
    checks++;
    if (act_vec() !== exp_vec(e)) $display("FAIL hold_rec: got %h, want %h", act_vec(), exp_vec(e));
    else passes++;
    checks++;
    if ({out_valid, overrun} !== 2'b11) $display("FAIL hold_flags: got valid/overrun %b, want 11", {out_valid, overrun});
    else passes++;
    accept();
    checks++;
    if (out_valid !== 1'b0) $display("FAIL hold_ack: got out_valid %b, want 0", out_valid);
    else passes++;
  endtask
  task automatic test_drop();
    exp_t e;
    int lat;
    do_reset();
    drive_frame(16, 4, 3, 4, 1, 2, 0, -1);
    drive_frame(2, 1, 0, 0, 0, 0, 0, -1);
    void'(q.pop_back());
    e = q.pop_front();
    wait_valid(e.eof_cyc, lat);
    checks++;
    if (lat !== 59) $display("FAIL drop_latency: got %0d, want 59", lat);
    else passes++;
    checks++;
    if (act_vec() !== exp_vec(e)) $display("FAIL drop_rec: got %h, want %h", act_vec(), exp_vec(e));
    else passes++;
    checks++;
    if (overrun !== 1'b1) $display("FAIL drop_overrun: got %b, want 1", overrun);
    else passes++;
    accept();
  endtask
  task automatic test_midframe_reset();
    exp_t e;
    int lat;
    drive_frame(64, 32, 10, 13, 20, 23, 0, 64 * 21 + 12);
    aresetn = 0;
    #1;
    checks++;
    if ({out_valid, overrun, act_vec()} !== '0) $display("FAIL midreset_zero: got valid %b overrun %b rec %h, want all 0", out_valid, overrun, act_vec());
    else passes++;
    tick();
    tick();
    aresetn = 1;
    tick();
    drive_frame(64, 32, 10, 13, 20, 23, 0, -1);
    e = q.pop_front();
    wait_valid(e.eof_cyc, lat);
    checks++;
    if (lat !== 59) $display("FAIL midreset_latency: got %0d, want 59", lat);
    else passes++;
    checks++;
    if (act_vec() !== exp_vec(e)) $display("FAIL midreset_rec: got %h, want %h", act_vec(), exp_vec(e));
    else passes++;
    accept();
  endtask
  initial begin
    test_reset();
    test_single();
    test_block();
    test_empty();
    test_gaps();
    test_hold_overrun();
    test_drop();
    test_midframe_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/motion_centroid_tracker.md
Name: motion_centroid_tracker

Overview:
Consumer of the thresholded binary delta-frame pixel stream. Scans each frame in raster order and accumulates per-frame motion statistics: foreground count, bounding box, and coordinate sums. At end of frame it snapshots the statistics and computes the centroid with a serial divider. It presents one result record per frame to the tracking/overlay logic over a valid/ready handshake.

Parameters:
INPUT_WIDTH, 10, width of incoming delta pixel; pixel is foreground when its MSB = 1
X_WIDTH, 10, column coordinate width
Y_WIDTH, 9, row coordinate width
CNT_WIDTH, 19, foreground-count width (= X_WIDTH + Y_WIDTH)
MIN_COUNT, 16, minimum foreground count for found = 1

Ports:
clk  in  1  clock
aresetn  in  1  async active-low reset
in_valid  in  1  pixel qualifier (deasserted during blanking)
in_sof  in  1  start of frame, qualified by in_valid, marks pixel (0,0)
in_eol  in  1  last pixel of line, qualified by in_valid
in_eof  in  1  last pixel of frame, qualified by in_valid
in_pixel  in  INPUT_WIDTH  delta-frame pixel
out_valid  out  1  result record valid
out_ready  in  1  consumer accepts record
found  out  1  count >= MIN_COUNT
count  out  CNT_WIDTH  foreground pixel count
x_min, x_max  out  X_WIDTH  bounding-box columns
y_min, y_max  out  Y_WIDTH  bounding-box rows
cx  out  X_WIDTH  centroid column
cy  out  Y_WIDTH  centroid row
overrun  out  1  sticky; a result was dropped or overwritten

Behaviour:
- Reset: clk, aresetn; reset is asynchronous, active-low. All outputs 0; both FSMs to idle; accumulators cleared. Reset mid-frame discards the partial frame; accumulation resumes at the next in_sof.
- Coordinates: advance only on in_valid. in_sof forces x = 0, y = 0 for that pixel. in_eol sets next x = 0, y + 1. Otherwise x + 1. x and y saturate at all-ones.
- Accumulate FSM: A_IDLE -> A_ACCUM on in_valid & in_sof. A_ACCUM -> A_IDLE on in_valid & in_eof. Pixels seen in A_IDLE are ignored.
- in_sof while in A_ACCUM restarts the frame: accumulators are cleared and the sof pixel is counted.
- Per foreground pixel: count += 1; sum_x += x; sum_y += y; update min/max.
- Widths: sum_x is X_WIDTH + CNT_WIDTH bits; sum_y is Y_WIDTH + CNT_WIDTH bits. Min registers init to all-ones, max registers to 0, at sof.
- EOF pixel is included in the statistics. On the cycle after the eof pixel, stats are snapshotted and accumulators cleared, so the next frame may start immediately.
- Result FSM: R_IDLE -> R_DIVX on snapshot. R_DIVX runs (X_WIDTH + CNT_WIDTH) cycles, then R_DIVY runs (Y_WIDTH + CNT_WIDTH) cycles, then R_HOLD.
- out_valid rises exactly 2 + 29 + 28 = 59 cycles (defaults) after the eof pixel cycle. Outputs are stable while out_valid = 1.
- R_HOLD -> R_IDLE on out_valid & out_ready.
- count = 0: divider is bypassed to quotient 0; bbox outputs are forced to 0; found = 0. Latency is unchanged.
- Boundary: snapshot while in R_HOLD replaces the pending record (out_valid stays 1) and sets overrun.
- Boundary: snapshot while in R_DIVX/R_DIVY drops the new frame and sets overrun.
- overrun clears only on reset.

Optional Feature:
MOTION_CENTROID_ROUND_EN
- Defined: numerator += count >> 1 before division, giving round-half-up.
- Undefined: truncating division.
- Latency is identical in both cases.

Decomposition:
- motion_tracker_pkg: width localparams, A_/R_ state enum typedefs, and a result-record struct typedef.
- Sub-module serial_divider: restoring, one quotient bit per cycle. Parameterised numerator and denominator widths; start/busy/done interface; divide-by-zero yields 0. It is instantiated once and reused for X then Y.

Test Plan:
- Single pixel (MIN_COUNT = 1): 8x4 frame, foreground only at (5,3) -> count 1, bbox 5/5/3/3, cx 5, cy 3, found 1, out_valid at eof + 59.
- 4x4 block at x 10..13, y 20..23 (64x32 frame) -> count 16, bbox 10/13/20/23, found 1. Without ROUND_EN: cx 11, cy 21. With ROUND_EN: cx 12, cy 22.
- Empty frame -> count 0, found 0, bbox and centroid all 0, latency 59.
- out_ready held low across two frames with counts 16 then 20 -> record shows count 20, overrun 1. A single out_ready pulse then deasserts out_valid.
- in_valid gaps: random in_valid = 0 cycles inside lines -> identical result to the gap-free run.
- aresetn pulsed mid-frame -> outputs 0. Next full frame with 4x4 block -> correct result, no residue from the partial frame.
